alu_seq_unit: RTL and testbench

//  Parametrised, handshaked successor to the 16-bit combinational ALU. Registers every result and adds a multi-cycle

---
 rtl/alu_seq_unit_if.sv | 39 +++
 rtl/alu_seq_unit.sv | 172 +++++++++++++++++
 tb/tb_alu_seq_unit.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_unit_if.sv
// Issue/writeback handshake bundle for alu_seq_unit.
// ALU_OVERFLOW_EN adds the Overflow signal to both modports.
interface alu_seq_unit_if #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [SHW-1:0]   shamt;
  logic [2:0]       ALUop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             busy;
`ifdef ALU_OVERFLOW_EN
  logic             Overflow;

  modport master (
    output in_valid, A, B, shamt, ALUop, out_ready,
    input  in_ready, out_valid, Result, Zero, busy, Overflow
  );
  modport slave (
    input  in_valid, A, B, shamt, ALUop, out_ready,
    output in_ready, out_valid, Result, Zero, busy, Overflow
  );
`else
  modport master (
    output in_valid, A, B, shamt, ALUop, out_ready,
    input  in_ready, out_valid, Result, Zero, busy
  );
  modport slave (
    input  in_valid, A, B, shamt, ALUop, out_ready,
    output in_ready, out_valid, Result, Zero, busy
  );
`endif
endinterface

// File: rtl/alu_seq_unit.sv
// Handshaked ALU with registered results and shift-add MUL.
// Optional macro ALU_OVERFLOW_EN adds a registered Overflow flag.
module alu_seq_unit #(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input logic           clk,
  input logic           rst_n,
  alu_seq_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
`ifdef ALU_OVERFLOW_EN
  localparam int PW = 2 * WIDTH;
`else
  localparam int PW = WIDTH;
`endif
  localparam int M = WIDTH - 1;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_SLL = 3'b011;
  localparam logic [2:0] OP_AND = 3'b100;
  localparam logic [2:0] OP_OR  = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b110;
  localparam logic [2:0] OP_SRL = 3'b111;

  typedef enum logic {S_IDLE, S_MUL} state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_res;
  logic             r_zero;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [WIDTH-1:0] r_mplier;

  logic             w_in_ready;
  logic             w_acc;
  logic             w_acc_mul;
  logic             w_fin;
  logic             w_busy;
  logic             w_load;
  logic             w_cnt_done;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_dif;
  logic [WIDTH-1:0] w_res;
  logic [WIDTH-1:0] w_nres;

  assign w_sum      = bus.A + bus.B;
  assign w_dif      = bus.A - bus.B;
  assign w_cnt_done = (r_cnt == CW'(WIDTH));
  assign w_load     = (w_acc && !w_acc_mul) || w_fin;
  assign w_nres     = w_fin ? r_acc[WIDTH-1:0] : w_res;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // next state, accept and completion strobes
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    w_acc      = 1'b0;
    w_acc_mul  = 1'b0;
    w_fin      = 1'b0;
    w_busy     = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = !r_out_valid || bus.out_ready;
        w_acc      = w_in_ready && bus.in_valid;
        w_acc_mul  = w_acc && (bus.ALUop == OP_MUL);
        if (w_acc_mul) w_next = S_MUL;
      end
      S_MUL: begin
        w_busy = 1'b1;
        if (w_cnt_done && (!r_out_valid || bus.out_ready)) begin
          w_fin  = 1'b1;
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // single-cycle op results
  always_comb begin
    w_res = '0;
    case (bus.ALUop)
      OP_ADD: w_res = w_sum;
      OP_SUB: w_res = w_dif;
      OP_MUL: w_res = '0;
      OP_SLL: w_res = bus.A << bus.shamt;
      OP_AND: w_res = bus.A & bus.B;
      OP_OR:  w_res = bus.A | bus.B;
      OP_SLT: w_res = {{(WIDTH-1){1'b0}},
                       ($signed(bus.A) < $signed(bus.B))};
      OP_SRL: w_res = bus.A >> bus.shamt;
    endcase
  end

  // shift-add multiplier, one partial product per cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_acc_mul) begin
      r_mcand  <= PW'(bus.A);
      r_mplier <= bus.B;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_busy && !w_cnt_done) begin
      if (r_mplier[0]) r_acc <= r_acc + r_mcand;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end else if (w_fin) begin
      r_cnt    <= '0;
    end
  end

  // output slot: load on result, clear when consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_zero      <= 1'b0;
    end else begin
      if (w_load) begin
        r_res  <= w_nres;
        r_zero <= (w_nres == '0);
      end
      if (w_load)             r_out_valid <= 1'b1;
      else if (bus.out_ready) r_out_valid <= 1'b0;
    end
  end

`ifdef ALU_OVERFLOW_EN
  logic r_ovf;
  logic w_ovf;

  // signed overflow for ADD/SUB; MUL uses the upper product half
  always_comb begin
    w_ovf = 1'b0;
    case (bus.ALUop)
      OP_ADD: w_ovf = (bus.A[M] == bus.B[M]) && (w_sum[M] != bus.A[M]);
      OP_SUB: w_ovf = (bus.A[M] != bus.B[M]) && (w_dif[M] != bus.A[M]);
      default: w_ovf = 1'b0;
    endcase
  end

  // overflow flag registered alongside Result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_ovf <= 1'b0;
    else if (w_load) r_ovf <= w_fin ? (|r_acc[PW-1:WIDTH]) : w_ovf;
  end

  assign bus.Overflow = r_ovf;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.Result    = r_res;
  assign bus.Zero      = r_zero;
  assign bus.busy      = w_busy;
endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed self-checking bench for alu_seq_unit (WIDTH=16).
// Define ALU_OVERFLOW_EN to also exercise the Overflow flag.
module tb_alu_seq_unit;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_err;
  int   bad;

  alu_seq_unit_if #(.WIDTH(16)) bus ();

  alu_seq_unit #(.WIDTH(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op,
                       input logic [15:0] a,
                       input logic [15:0] b,
                       input logic [3:0] sh);
    bus.ALUop    = op;
    bus.A        = a;
    bus.B        = b;
    bus.shamt    = sh;
    bus.in_valid = 1'b1;
  endtask

  task automatic single(input string tag,
                        input logic [2:0] op,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic [3:0] sh,
                        input logic [15:0] er,
                        input logic ez);
    drive(op, a, b, sh);
    chk({tag, "_rdy"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk({tag, "_ov"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_res"}, 32'(bus.Result), 32'(er));
    chk({tag, "_z"}, 32'(bus.Zero), 32'(ez));
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.shamt     = '0;
    bus.ALUop     = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ov", 32'(bus.out_valid), 32'd0);
    chk("rst_res", 32'(bus.Result), 32'd0);
    chk("rst_z", 32'(bus.Zero), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
`ifdef ALU_OVERFLOW_EN
    chk("rst_ovf", 32'(bus.Overflow), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);

    single("add", 3'b000, 16'd16, 16'd34, 4'd0, 16'd50, 1'b0);
    single("sub", 3'b001, 16'd100, 16'd100, 4'd0, 16'd0, 1'b1);
    single("slt1", 3'b110, 16'hFFFB, 16'd3, 4'd0, 16'd1, 1'b0);
    single("slt0", 3'b110, 16'd100, 16'd47, 4'd0, 16'd0, 1'b1);
    single("and", 3'b100, 16'hABDF, 16'h9ECF, 4'd0, 16'h8ACF, 1'b0);
    single("or", 3'b101, 16'hABDF, 16'h9ECF, 4'd0, 16'hBFDF, 1'b0);
    single("sll0", 3'b011, 16'h1234, 16'hFFFF, 4'd0, 16'h1234, 1'b0);

    drive(3'b011, 16'hDEDE, 16'h0000, 4'd1);
    @(negedge clk);
    chk("b2b_sll", 32'(bus.Result), 32'hBDBC);
    chk("b2b_rdy", 32'(bus.in_ready), 32'd1);
    drive(3'b111, 16'hBABA, 16'h0000, 4'd2);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("b2b_ov", 32'(bus.out_valid), 32'd1);
    chk("b2b_srl", 32'(bus.Result), 32'h2EAE);
    @(negedge clk);

    drive(3'b010, 16'd300, 16'd7, 4'd0);
    chk("mul_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 17; i++) begin
      if (!bus.busy || bus.in_ready || bus.out_valid) bad++;
      bus.A = 16'(16'hFFFF - i * 77);
      bus.B = 16'(i * 311 + 5);
      @(negedge clk);
    end
    chk("mul_busy", 32'(bad), 32'd0);
    chk("mul_ov", 32'(bus.out_valid), 32'd1);
    chk("mul_res", 32'(bus.Result), 32'h0834);
    chk("mul_done", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("mul_drain", 32'(bus.out_valid), 32'd0);

    bus.out_ready = 1'b0;
    drive(3'b000, 16'd16, 16'd34, 4'd0);
    @(negedge clk);
    drive(3'b001, 16'd100, 16'd100, 4'd0);
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.Result !== 16'd50 || bus.Zero !== 1'b0) bad++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("stall_hold", 32'(bad), 32'd0);
    chk("stall_res", 32'(bus.Result), 32'd50);
    bus.out_ready = 1'b1;
    #1;
    chk("stall_rel_rdy", 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("stall_next_res", 32'(bus.Result), 32'd0);
    chk("stall_next_z", 32'(bus.Zero), 32'd1);

    single("pre", 3'b000, 16'd16, 16'd34, 4'd0, 16'd50, 1'b0);
    drive(3'b010, 16'd300, 16'd7, 4'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_ov", 32'(bus.out_valid), 32'd0);
    chk("abort_res", 32'(bus.Result), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("abort_rdy", 32'(bus.in_ready), 32'd1);
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
      @(negedge clk);
    end
    chk("abort_stale", 32'(bad), 32'd0);

`ifdef ALU_OVERFLOW_EN
    single("ovf_add", 3'b000, 16'h7FFF, 16'h0001, 4'd0, 16'h8000, 1'b0);
    chk("ovf_add_f", 32'(bus.Overflow), 32'd1);
    single("ovf_and", 3'b100, 16'hFFFF, 16'h00F0, 4'd0, 16'h00F0, 1'b0);
    chk("ovf_and_f", 32'(bus.Overflow), 32'd0);
    drive(3'b010, 16'h0100, 16'h0100, 4'd0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (17) @(negedge clk);
    chk("ovf_mul_ov", 32'(bus.out_valid), 32'd1);
    chk("ovf_mul_res", 32'(bus.Result), 32'd0);
    chk("ovf_mul_z", 32'(bus.Zero), 32'd1);
    chk("ovf_mul_f", 32'(bus.Overflow), 32'd1);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
